mispredict_recovery_ctrl: RTL and testbench

//  Sequences pipeline recovery after the retire stage flags a mispredicted branch at the ROB head.

---
 rtl/mispredict_recovery_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mispredict_recovery_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mispredict_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// mispredict_recovery_ctrl
//
// Sequences pipeline recovery after retire flags a mispredicted branch at the
// ROB head: a global flush pulse, then a chunked copy of the architectural map
// table into the speculative map table, then a redirect PC handed to fetch
// over a valid/ready handshake. Retire and dispatch stay stalled throughout.
//
// Ports
//   clock               in   system clock
//   reset               in   synchronous, active-high
//   mispredict          in   retire-stage mispredict pulse (sampled in IDLE only)
//   mispred_target      in   correct next PC of the mispredicted branch
//   redirect_ready      in   fetch accepts the redirect
//   flush_o             out  squash ROB/RS/FU/fetch queues
//   freelist_rebuild_o  out  one-cycle pulse in the first restore cycle
//   restore_en_o        out  copy one arch->spec map chunk this cycle
//   restore_base_o      out  first arch register index of the chunk
//   restore_mask_o      out  per-lane valid (index < ARCH_COUNT)
//   redirect_valid_o    out  redirect PC valid to fetch
//   redirect_pc_o       out  captured mispred_target (0 outside REDIRECT)
//   stall_retire_o      out  block retire commits
//   stall_dispatch_o    out  block dispatch
//   busy_o              out  sequencer not idle
//   recovery_count_o    out  recoveries started, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

module mispredict_recovery_ctrl #(
  parameter int ARCH_COUNT   = `ARCH_REG_SZ,
  parameter int COPY_W       = 8,
  parameter int FLUSH_CYCLES = 1,
  parameter int ADDR_W       = 32,
  localparam int BASE_W      = (ARCH_COUNT > 1) ? $clog2(ARCH_COUNT) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mispredict,
  input  logic [ADDR_W-1:0] mispred_target,
  input  logic              redirect_ready,
  output logic              flush_o,
  output logic              freelist_rebuild_o,
  output logic              restore_en_o,
  output logic [BASE_W-1:0] restore_base_o,
  output logic [COPY_W-1:0] restore_mask_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              stall_retire_o,
  output logic              stall_dispatch_o,
  output logic              busy_o,
  output logic [15:0]       recovery_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_RESTORE,
    S_REDIRECT
  } state_t;

  // The chunk base runs one step past the last chunk before the sequencer
  // leaves RESTORE, so it is kept wide enough to hold ARCH_COUNT + COPY_W.
  localparam int IDX_W = $clog2(ARCH_COUNT + COPY_W + 1);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LP_COPY       = IDX_W'(COPY_W);
  localparam logic [IDX_W-1:0] LP_COUNT      = IDX_W'(ARCH_COUNT);
  localparam logic [FC_W-1:0]  LP_FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [FC_W-1:0]     r_flush_cnt;
  logic [IDX_W-1:0]    r_base;
  logic [ADDR_W-1:0]   r_pc;
  logic [15:0]         r_count;

  logic                w_accept;
  logic                w_flush_done;
  logic                w_last_chunk;
  logic [COPY_W-1:0]   w_mask;

  assign w_accept     = (r_state == S_IDLE) && mispredict;
  assign w_flush_done = (r_flush_cnt == '0);
  assign w_last_chunk = ((r_base + LP_COPY) >= LP_COUNT);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:     if (mispredict)     w_next_state = S_FLUSH;
      S_FLUSH:    if (w_flush_done)   w_next_state = S_RESTORE;
      S_RESTORE:  if (w_last_chunk)   w_next_state = S_REDIRECT;
      S_REDIRECT: if (redirect_ready) w_next_state = S_IDLE;
      default:                        w_next_state = S_IDLE;
    endcase
  end

  // Sequence bookkeeping: captured target, flush down-counter, chunk base
  // and the saturating recovery counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_flush_cnt <= '0;
      r_base      <= '0;
      r_pc        <= '0;
      r_count     <= '0;
    end else begin
      if (w_accept) begin
        r_pc        <= mispred_target;
        r_flush_cnt <= LP_FLUSH_LOAD;
        r_base      <= '0;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
      if ((r_state == S_FLUSH) && !w_flush_done) r_flush_cnt <= r_flush_cnt - FC_W'(1);
      if (r_state == S_RESTORE)                  r_base      <= r_base + LP_COPY;
    end
  end

  // Lane i of the current chunk is live only while its register index is in
  // range; this trims the final chunk when COPY_W does not divide ARCH_COUNT.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < COPY_W; i++) begin
      w_mask[i] = ((r_base + IDX_W'(i)) < LP_COUNT);
    end
  end

  // Output decode from registered state only.
  always_comb begin
    flush_o            = 1'b0;
    freelist_rebuild_o = 1'b0;
    restore_en_o       = 1'b0;
    restore_base_o     = '0;
    restore_mask_o     = '0;
    redirect_valid_o   = 1'b0;
    redirect_pc_o      = '0;
    unique case (r_state)
      S_FLUSH: flush_o = 1'b1;
      S_RESTORE: begin
        restore_en_o       = 1'b1;
        restore_base_o     = BASE_W'(r_base);
        restore_mask_o     = w_mask;
        freelist_rebuild_o = (r_base == '0);
      end
      S_REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = r_pc;
      end
      default: ;
    endcase
  end

  assign stall_retire_o   = (r_state != S_IDLE);
  assign stall_dispatch_o = (r_state != S_IDLE);
  assign busy_o           = (r_state != S_IDLE);
  assign recovery_count_o = r_count;

endmodule

// File: tb/tb_mispredict_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mispredict_recovery_ctrl
//
// Two instances: A (ARCH_COUNT=32, COPY_W=8, FLUSH_CYCLES=1) and
// B (ARCH_COUNT=20, COPY_W=8, FLUSH_CYCLES=2). Only the selected instance
// receives stimulus. The stimulus side pushes cycle-stamped expected output
// snapshots into a queue; the monitor pops one whenever the selected DUT shows
// activity and checks that idle cycles show nothing but the counter.
// -----------------------------------------------------------------------------
module tb_mispredict_recovery_ctrl;

  typedef struct packed {
    logic        flush;
    logic        rebuild;
    logic        en;
    logic [4:0]  base;
    logic [7:0]  mask;
    logic        valid;
    logic [31:0] pc;
    logic        stall_r;
    logic        stall_d;
    logic        busy;
    logic [15:0] count;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mispredict = 1'b0;
  logic [31:0] mispred_target = '0;
  logic        redirect_ready = 1'b0;
  logic        sel = 1'b0;
  logic        mon_en = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  ev_t         exp_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic mp_a, mp_b, rdy_a, rdy_b;
  assign mp_a  = mispredict & ~sel;
  assign mp_b  = mispredict & sel;
  assign rdy_a = redirect_ready & ~sel;
  assign rdy_b = redirect_ready & sel;

  logic        a_flush, a_rebuild, a_en, a_valid, a_stall_r, a_stall_d, a_busy;
  logic [4:0]  a_base;
  logic [7:0]  a_mask;
  logic [31:0] a_pc;
  logic [15:0] a_count;
  logic        b_flush, b_rebuild, b_en, b_valid, b_stall_r, b_stall_d, b_busy;
  logic [4:0]  b_base;
  logic [7:0]  b_mask;
  logic [31:0] b_pc;
  logic [15:0] b_count;

  mispredict_recovery_ctrl #(.ARCH_COUNT(32), .COPY_W(8), .FLUSH_CYCLES(1), .ADDR_W(32)) u_dut_a (
    .clock(clock), .reset(reset), .mispredict(mp_a), .mispred_target(mispred_target),
    .redirect_ready(rdy_a), .flush_o(a_flush), .freelist_rebuild_o(a_rebuild),
    .restore_en_o(a_en), .restore_base_o(a_base), .restore_mask_o(a_mask),
    .redirect_valid_o(a_valid), .redirect_pc_o(a_pc), .stall_retire_o(a_stall_r),
    .stall_dispatch_o(a_stall_d), .busy_o(a_busy), .recovery_count_o(a_count)
  );

  mispredict_recovery_ctrl #(.ARCH_COUNT(20), .COPY_W(8), .FLUSH_CYCLES(2), .ADDR_W(32)) u_dut_b (
    .clock(clock), .reset(reset), .mispredict(mp_b), .mispred_target(mispred_target),
    .redirect_ready(rdy_b), .flush_o(b_flush), .freelist_rebuild_o(b_rebuild),
    .restore_en_o(b_en), .restore_base_o(b_base), .restore_mask_o(b_mask),
    .redirect_valid_o(b_valid), .redirect_pc_o(b_pc), .stall_retire_o(b_stall_r),
    .stall_dispatch_o(b_stall_d), .busy_o(b_busy), .recovery_count_o(b_count)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {a_flush, a_rebuild, a_en, a_base, a_mask, a_valid, a_pc,
                  a_stall_r, a_stall_d, a_busy, a_count};
  assign obs_b = {b_flush, b_rebuild, b_en, b_base, b_mask, b_valid, b_pc,
                  b_stall_r, b_stall_d, b_busy, b_count};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Hand-computed {base, mask} for chunk k of each configuration.
  function automatic logic [12:0] chunk_exp(input logic s, input int k);
    logic [12:0] r;
    r = '0;
    if (!s) begin
      case (k)
        0: r = {5'd0,  8'hFF};
        1: r = {5'd8,  8'hFF};
        2: r = {5'd16, 8'hFF};
        3: r = {5'd24, 8'hFF};
        default: r = '0;
      endcase
    end else begin
      case (k)
        0: r = {5'd0,  8'hFF};
        1: r = {5'd8,  8'hFF};
        2: r = {5'd16, 8'h0F};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // kind: 0 = flush cycle, 1 = restore chunk k, 2 = redirect cycle.
  function automatic obs_t mk(input int kind, input logic s, input int k,
                              input logic [31:0] pc, input logic [15:0] cnt);
    obs_t o;
    o = '0;
    o.stall_r = 1'b1;
    o.stall_d = 1'b1;
    o.busy    = 1'b1;
    o.count   = cnt;
    case (kind)
      0: o.flush = 1'b1;
      1: begin
        o.en           = 1'b1;
        o.rebuild      = (k == 0);
        {o.base, o.mask} = chunk_exp(s, k);
      end
      default: begin
        o.valid = 1'b1;
        o.pc    = pc;
      end
    endcase
    return o;
  endfunction

  task automatic push(input int c, input obs_t o);
    ev_t e;
    e.cyc = c;
    e.o   = o;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      mispredict     = 1'b0;
      redirect_ready = rdy;
      step();
    end
  endtask

  // Issues a mispredict in the current cycle and drives the sequence through
  // its handshake. ready_delay = number of REDIRECT cycles with ready low.
  // noise: extra mispredicts (target 0x200) throughout FLUSH/RESTORE.
  // hs_mp: mispredict (target 0x200) in the handshake cycle.
  // Returns one cycle after the handshake.
  task automatic run_seq(input logic [31:0] target, input int ready_delay,
                         input logic [15:0] cnt, input bit noise, input bit hs_mp);
    int c0, f_n, ch_n, c_redir, c_hs;
    f_n     = sel ? 2 : 1;
    ch_n    = sel ? 3 : 4;
    c0      = cyc;
    c_redir = c0 + f_n + ch_n + 1;
    c_hs    = c_redir + ready_delay;
    for (int f = 1; f <= f_n; f++) push(c0 + f, mk(0, sel, 0, 0, cnt));
    for (int k = 0; k < ch_n; k++) push(c0 + f_n + 1 + k, mk(1, sel, k, 0, cnt));
    for (int c = c_redir; c <= c_hs; c++) push(c, mk(2, sel, 0, target, cnt));
    mispredict     = 1'b1;
    mispred_target = target;
    redirect_ready = 1'b1;
    for (int c = c0 + 1; c <= c_hs; c++) begin
      step();
      mispredict = noise && (c <= c0 + f_n + ch_n);
      if (noise) mispred_target = 32'h200;
      redirect_ready = (c < c_redir) || (c == c_hs);
      if ((c == c_hs) && hs_mp) begin
        mispredict     = 1'b1;
        mispred_target = 32'h200;
      end
    end
    step();
    mispredict     = 1'b0;
    redirect_ready = 1'b0;
  endtask

  // Monitor: activity pops and compares a full output snapshot; idle cycles
  // must show every output except the counter at zero.
  always @(negedge clock) begin
    obs_t o, om;
    ev_t  e;
    if (mon_en) begin
      o = sel ? obs_b : obs_a;
      if (o.flush || o.en || o.valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_activity cyc=%0d got=%h", cyc, o);
        end else begin
          e = exp_q.pop_front();
          if ((e.cyc != cyc) || (o !== e.o)) begin
            n_bad++;
            $display("FAIL event cyc=%0d got=%h expected=%h at cyc %0d", cyc, o, e.o, e.cyc);
          end
        end
      end else begin
        om       = o;
        om.count = '0;
        n_cmp++;
        if (om !== '0) begin
          n_bad++;
          $display("FAIL idle_outputs cyc=%0d got=%h expected=0 (count ignored)", cyc, om);
        end
        if ((exp_q.size() > 0) && (exp_q[0].cyc <= cyc)) begin
          e = exp_q.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missing_event cyc=%0d got=%h expected=%h", cyc, o, e.o);
        end
      end
    end
  end

  initial begin
    int c0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state_a", obs_a, 0);
    check("reset_state_b", obs_b, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Ready high while idle must do nothing.
    idle(2, 1'b1);

    // Basic sequence: flush c+1, chunks c+2..c+5, redirect c+6, idle c+7.
    run_seq(32'h100, 0, 16'd1, 1'b0, 1'b0);
    check("busy_after_handshake", a_busy, 0);
    check("count_after_first", a_count, 16'd1);
    idle(2, 1'b0);

    // Backpressure, ignored mispredicts during FLUSH/RESTORE and in the
    // handshake cycle, then a back-to-back recovery in the next cycle.
    run_seq(32'h1234, 3, 16'd2, 1'b1, 1'b1);
    run_seq(32'h300, 0, 16'd3, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("count_after_third", a_count, 16'd3);

    // Reset during the second RESTORE cycle aborts without a redirect.
    c0 = cyc;
    push(c0 + 1, mk(0, 1'b0, 0, 0, 16'd4));
    push(c0 + 2, mk(1, 1'b0, 0, 0, 16'd4));
    push(c0 + 3, mk(1, 1'b0, 1, 0, 16'd4));
    mispredict     = 1'b1;
    mispred_target = 32'h400;
    step();
    mispredict = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check("reset_mid_restore_outputs", obs_a, 0);
    reset = 1'b0;
    idle(10, 1'b1);

    // Config B: partial last chunk, two flush cycles, one stalled redirect.
    sel = 1'b1;
    idle(1, 1'b0);
    run_seq(32'hABC0, 1, 16'd1, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("count_b", b_count, 16'd1);
    check("count_a_after_abort", a_count, 16'd0);

    check("leftover_expected_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
